// File: rtl/tick_timeout_counter_if.sv
// Control and status bundle between the tick timeout counter and its controller.
// The master drives the controls and the counter (slave) returns its registered status.
interface tick_timeout_counter_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             tick_in;
  logic             restart;
  logic             tc_load;
  logic [CNT_W-1:0] tc_value;
  logic             mode_load;
  logic             mode_in;
  logic [CNT_W-1:0] count;
  logic             timeout;
  logic             done;
  logic             busy;

  modport master (
    output enable, tick_in, restart, tc_load, tc_value, mode_load, mode_in,
    input  count, timeout, done, busy
  );

  modport slave (
    input  enable, tick_in, restart, tc_load, tc_value, mode_load, mode_in,
    output count, timeout, done, busy
  );
endinterface

// File: rtl/tick_timeout_counter.sv
// Counts tick strobes up to a loadable terminal count and pulses timeout; periodic or one-shot.
// All outputs are registered (one cycle after the causing input); there is no backpressure.
module tick_timeout_counter #(
  parameter int CNT_W      = 16,
  parameter int DEFAULT_TC = 100,
  parameter bit ONE_SHOT   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  tick_timeout_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TC_RST = (DEFAULT_TC < 1) ? CNT_W'(1) : CNT_W'(DEFAULT_TC);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] tc_q, tc_d;
  logic             mode_q, mode_d;
  logic             timeout_q, timeout_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] tc_load_val;
  logic             terminal;

  // A terminal count of zero would never expire, so it is treated as one.
  assign tc_load_val = (bus.tc_value == '0) ? CNT_W'(1) : bus.tc_value;
  assign terminal    = (count_q == (tc_q - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      tc_q      <= TC_RST;
      mode_q    <= ONE_SHOT;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tc_q      <= tc_d;
      mode_q    <= mode_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    tc_d      = tc_q;
    mode_d    = mode_q;
    timeout_d = 1'b0;

    if (!bus.enable) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      // Register loads happen whenever enabled; the priority chain below only decides
      // what the count and state do in the same cycle.
      if (bus.tc_load) begin
        tc_d = tc_load_val;
      end
      if (bus.mode_load) begin
        mode_d = bus.mode_in;
      end

      if (bus.restart) begin
        state_d = RUN;
        count_d = '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_d = RUN;
            count_d = '0;
          end
          RUN: begin
            if (bus.tc_load) begin
              count_d = '0;
            end else if (bus.tick_in) begin
              if (terminal) begin
                count_d   = '0;
                timeout_d = 1'b1;
                if (mode_q) begin
                  state_d = DONE;
                end
              end else begin
                count_d = count_q + CNT_W'(1);
              end
            end
          end
          DONE: begin
            count_d = '0;
          end
          default: begin
            state_d = IDLE;
            count_d = '0;
          end
        endcase
      end
    end

    done_d = (state_d == DONE);
    busy_d = (state_d == RUN);
  end

  assign bus.count   = count_q;
  assign bus.timeout = timeout_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;

  a_tc_nonzero:   assert property (@(posedge clk) disable iff (!rst) tc_q != '0);
  a_count_in_rng: assert property (@(posedge clk) disable iff (!rst) count_q < tc_q);
  a_done_not_run: assert property (@(posedge clk) disable iff (!rst) !(done_q && busy_q));

endmodule

// File: tb/tb_tick_timeout_counter.sv
// Bench for tick_timeout_counter: fixed vector table, directed corner sequences, random run vs model.
module tb_tick_timeout_counter;
  localparam int CNT_W  = 16;
  localparam int DEF_TC = 100;

  logic clk = 1'b0;
  logic rst;

  tick_timeout_counter_if #(.CNT_W(CNT_W)) bus ();

  tick_timeout_counter #(
    .CNT_W     (CNT_W),
    .DEFAULT_TC(DEF_TC),
    .ONE_SHOT  (1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: tracks ticks remaining until the next timeout.
  int m_phase;   // 0 idle, 1 running, 2 finished (one-shot)
  int m_tc;
  int m_left;
  bit m_oneshot;
  bit m_to;

  task automatic model_step(input bit r, e, t, rs, tl, input int tv, input bit ml, mi);
    bit zero;
    zero = 1'b0;
    m_to = 1'b0;
    if (!r) begin
      m_phase = 0; m_tc = DEF_TC; m_oneshot = 1'b0; m_left = DEF_TC;
    end else if (!e) begin
      m_phase = 0; m_left = m_tc;
    end else begin
      if (rs) begin
        m_phase = 1; zero = 1'b1;
      end else if (m_phase == 0) begin
        m_phase = 1; zero = 1'b1;
      end else if (tl) begin
        zero = 1'b1;
      end else if (t && m_phase == 1) begin
        if (m_left == 1) begin
          m_to = 1'b1;
          zero = 1'b1;
          if (m_oneshot) m_phase = 2;
        end else begin
          m_left = m_left - 1;
        end
      end
      if (tl) m_tc = (tv == 0) ? 1 : tv;
      if (ml) m_oneshot = mi;
      if (zero) m_left = m_tc;
    end
  endtask

  task automatic cyc(input bit r, e, t, rs, tl, input int tv, input bit ml, mi);
    int exp_count;
    rst           = r;
    bus.enable    = e;
    bus.tick_in   = t;
    bus.restart   = rs;
    bus.tc_load   = tl;
    bus.tc_value  = CNT_W'(tv);
    bus.mode_load = ml;
    bus.mode_in   = mi;
    @(posedge clk);
    model_step(r, e, t, rs, tl, tv, ml, mi);
    #1;
    exp_count = (m_phase == 1) ? (m_tc - m_left) : 0;
    check("model_count",   32'(bus.count),   32'(exp_count));
    check("model_timeout", 32'(bus.timeout), 32'(m_to));
    check("model_done",    32'(bus.done),    32'(m_phase == 2));
    check("model_busy",    32'(bus.busy),    32'(m_phase == 1));
  endtask

  task automatic tick(); cyc(1, 1, 1, 0, 0, 0, 0, 0); endtask
  task automatic idle(); cyc(1, 1, 0, 0, 0, 0, 0, 0); endtask

  typedef struct {
    bit r, e, t, rs, tl;
    int tv;
    bit ml, mi;
    int xc;
    bit xt, xd, xb;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(bit r, e, t, rs, tl, int tv, bit ml, mi, int xc, bit xt, xd, xb);
    vec_t v;
    v.r = r; v.e = e; v.t = t; v.rs = rs; v.tl = tl; v.tv = tv; v.ml = ml; v.mi = mi;
    v.xc = xc; v.xt = xt; v.xd = xd; v.xb = xb;
    return v;
  endfunction

  initial begin
    //            r e t rs tl tv ml mi   cnt to dn by
    vecs[0]  = mk(0,0,0,0, 0, 0, 0, 0,   0,  0, 0, 0);
    vecs[1]  = mk(1,0,0,0, 0, 0, 0, 0,   0,  0, 0, 0);
    vecs[2]  = mk(1,1,0,0, 0, 0, 0, 0,   0,  0, 0, 1);
    vecs[3]  = mk(1,1,0,0, 1, 3, 0, 0,   0,  0, 0, 1);
    vecs[4]  = mk(1,1,1,0, 0, 0, 0, 0,   1,  0, 0, 1);
    vecs[5]  = mk(1,1,1,0, 0, 0, 0, 0,   2,  0, 0, 1);
    vecs[6]  = mk(1,1,1,0, 0, 0, 0, 0,   0,  1, 0, 1);
    vecs[7]  = mk(1,1,0,0, 0, 0, 0, 0,   0,  0, 0, 1);
    vecs[8]  = mk(1,1,0,0, 0, 0, 1, 1,   0,  0, 0, 1);
    vecs[9]  = mk(1,1,1,0, 0, 0, 0, 0,   1,  0, 0, 1);
    vecs[10] = mk(1,1,1,0, 0, 0, 0, 0,   2,  0, 0, 1);
    vecs[11] = mk(1,1,1,1, 0, 0, 0, 0,   0,  0, 0, 1);
    vecs[12] = mk(1,1,1,0, 0, 0, 0, 0,   1,  0, 0, 1);
    vecs[13] = mk(1,1,1,0, 0, 0, 0, 0,   2,  0, 0, 1);
    vecs[14] = mk(1,1,1,0, 0, 0, 0, 0,   0,  1, 1, 0);
    vecs[15] = mk(1,1,1,0, 0, 0, 0, 0,   0,  0, 1, 0);
    vecs[16] = mk(1,1,0,1, 0, 0, 0, 0,   0,  0, 0, 1);
    vecs[17] = mk(1,0,0,0, 0, 0, 0, 0,   0,  0, 0, 0);
    vecs[18] = mk(1,1,1,0, 0, 0, 0, 0,   0,  0, 0, 1);
    vecs[19] = mk(1,1,0,0, 1, 0, 0, 0,   0,  0, 0, 1);
    vecs[20] = mk(1,1,1,0, 0, 0, 0, 0,   0,  1, 1, 0);
    vecs[21] = mk(1,1,0,1, 0, 0, 1, 0,   0,  0, 0, 1);
    vecs[22] = mk(1,1,1,0, 0, 0, 0, 0,   0,  1, 0, 1);
    vecs[23] = mk(1,1,1,0, 0, 0, 0, 0,   0,  1, 0, 1);
    vecs[24] = mk(0,1,1,0, 0, 0, 0, 0,   0,  0, 0, 0);

    rst = 1'b0;
    bus.enable = 1'b0; bus.tick_in = 1'b0; bus.restart = 1'b0; bus.tc_load = 1'b0;
    bus.tc_value = '0; bus.mode_load = 1'b0; bus.mode_in = 1'b0;
    m_phase = 0; m_tc = DEF_TC; m_left = DEF_TC; m_oneshot = 1'b0; m_to = 1'b0;

    for (int i = 0; i < 25; i++) begin
      cyc(vecs[i].r, vecs[i].e, vecs[i].t, vecs[i].rs, vecs[i].tl, vecs[i].tv, vecs[i].ml, vecs[i].mi);
      check($sformatf("vec%0d_count", i),   32'(bus.count),   32'(vecs[i].xc));
      check($sformatf("vec%0d_timeout", i), 32'(bus.timeout), 32'(vecs[i].xt));
      check($sformatf("vec%0d_done", i),    32'(bus.done),    32'(vecs[i].xd));
      check($sformatf("vec%0d_busy", i),    32'(bus.busy),    32'(vecs[i].xb));
    end

    // Periodic default terminal count: timeouts after tick 100 and tick 200.
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (i == 99)  check("per_cnt99", 32'(bus.count), 32'd99);
      if (i == 99)  check("per_to99", 32'(bus.timeout), 32'd0);
      if (i == 100) check("per_to100", 32'(bus.timeout), 32'd1);
      if (i == 100) check("per_cnt100", 32'(bus.count), 32'd0);
      if (i == 200) check("per_to200", 32'(bus.timeout), 32'd1);
    end
    idle();
    check("per_pulse_width", 32'(bus.timeout), 32'd0);

    // One-shot with tc=3.
    cyc(1, 1, 0, 0, 1, 3, 1, 1);
    tick(); tick(); tick();
    check("os_timeout", 32'(bus.timeout), 32'd1);
    check("os_done", 32'(bus.done), 32'd1);
    check("os_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("os_hold_cnt", 32'(bus.count), 32'd0);
      check("os_hold_to", 32'(bus.timeout), 32'd0);
    end
    cyc(1, 1, 0, 1, 0, 0, 0, 0);
    check("os_restart_done", 32'(bus.done), 32'd0);
    check("os_restart_busy", 32'(bus.busy), 32'd1);

    // tc_value 0 clamps to 1: every tick times out.
    cyc(1, 1, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("tc1_timeout", 32'(bus.timeout), 32'd1);
    end

    // Restart on the terminal tick suppresses the timeout.
    cyc(1, 1, 0, 0, 1, 5, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    check("rs_cnt4", 32'(bus.count), 32'd4);
    cyc(1, 1, 1, 1, 0, 0, 0, 0);
    check("rs_to", 32'(bus.timeout), 32'd0);
    check("rs_cnt", 32'(bus.count), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("rs_after_to", 32'(bus.timeout), 32'(i == 5));
    end

    // Drop enable mid-period, then a fresh full period; then reset mid-run.
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 50; i++) tick();
    check("en_cnt50", 32'(bus.count), 32'd50);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    check("en_off_cnt", 32'(bus.count), 32'd0);
    check("en_off_to", 32'(bus.timeout), 32'd0);
    idle();
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i == 99)  check("en_fresh_to99", 32'(bus.timeout), 32'd0);
      if (i == 100) check("en_fresh_to100", 32'(bus.timeout), 32'd1);
    end
    cyc(1, 1, 0, 0, 1, 7, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    check("rst_cnt", 32'(bus.count), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    idle();
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i == 7)   check("rst_tc_not7", 32'(bus.timeout), 32'd0);
      if (i == 100) check("rst_tc100", 32'(bus.timeout), 32'd1);
    end

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cyc(bit'($urandom_range(0, 199) != 0),
          bit'($urandom_range(0, 49) != 0),
          bit'($urandom_range(0, 1)),
          bit'($urandom_range(0, 29) == 0),
          bit'($urandom_range(0, 29) == 0),
          int'($urandom_range(0, 7)),
          bit'($urandom_range(0, 19) == 0),
          bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
